// File: rtl/mult8_err_monitor_if.sv
// ---------------------------------------------------------------------------
// mult8_err_monitor_if
// Valid/ready stream that carries one (approximate, exact) product pair per
// transfer from a multiplier partition under evaluation to the error monitor.
//
// Signals
//   in_valid  producer -> monitor  pair on approx/exact is valid
//   in_ready  monitor  -> producer monitor accepts the pair this cycle
//   approx    producer -> monitor  approximate product (unsigned, W bits)
//   exact     producer -> monitor  exact product (unsigned, W bits)
//
// Modports
//   master  producer side (drives valid and data)
//   slave   monitor side (drives ready)
// ---------------------------------------------------------------------------
interface mult8_err_monitor_if #(
  parameter int W = 16
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] approx;
  logic [W-1:0] exact;

  modport master (
    output in_valid,
    output approx,
    output exact,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  approx,
    input  exact,
    output in_ready
  );

endinterface : mult8_err_monitor_if

// File: rtl/mult8_err_monitor.sv
// ---------------------------------------------------------------------------
// mult8_err_monitor
// Accumulates error metrics of an approximate multiplier against the exact
// product over a programmed run of samples. Each accepted pair goes through
// a two-stage pipeline: stage 1 registers |approx-exact|, the mismatch flag
// and the Hamming distance; stage 2 folds them into the accumulators.
//
// Parameters
//   W      product width
//   CNT_W  sample counter / err_count width
//   SUM_W  sum_abs_err / hd_total width
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        1-cycle pulse; accepted in IDLE or DONE only
//   num_samples  run length, captured on an accepted start
//   pair         slave side of the approx/exact valid/ready stream
//   busy         run in progress (RUN or DRAIN)
//   done         metrics final; held until the next accepted start
//   err_count    samples with approx != exact
//   sum_abs_err  saturating sum of |approx-exact|
//   max_abs_err  maximum |approx-exact|
//   hd_total     saturating sum of popcount(approx ^ exact)
// ---------------------------------------------------------------------------
module mult8_err_monitor #(
  parameter int W     = 16,
  parameter int CNT_W = 16,
  parameter int SUM_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_samples,
  mult8_err_monitor_if.slave   pair,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     err_count,
  output logic [SUM_W-1:0]     sum_abs_err,
  output logic [W-1:0]         max_abs_err,
  output logic [SUM_W-1:0]     hd_total
);

  // Hamming distance of two W-bit words needs to represent 0..W.
  localparam int HD_W = $clog2(W + 1);
  // Accumulator adds are done one bit wider than the larger operand so the
  // carry out can be detected regardless of how SUM_W compares with W.
  localparam int AW = ((SUM_W > W) ? SUM_W : W) + 1;
  localparam logic [SUM_W-1:0] SUM_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state, next_state;

  logic             accept_start;
  logic             ready;
  logic             xfer;
  logic [CNT_W-1:0] remaining;

  // Stage 1 registers.
  logic             s1_valid;
  logic [W-1:0]     s1_d;
  logic             s1_mism;
  logic [HD_W-1:0]  s1_hd;

  // Stage 1 combinational terms.
  logic [W:0]       diff;
  logic [W-1:0]     abs_d;
  logic [HD_W-1:0]  hd_c;

  // Stage 2 combinational terms.
  logic [AW-1:0]    sum_next;
  logic [AW-1:0]    hd_next;
  logic [SUM_W-1:0] sum_sat;
  logic [SUM_W-1:0] hd_sat;

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement or process order.
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    next_state   = state;
    accept_start = 1'b0;
    ready        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    unique case (state)
      ST_IDLE, ST_DONE: begin
        done = (state == ST_DONE);
        if (start) begin
          accept_start = 1'b1;
          // An empty run has nothing to measure: report cleared metrics.
          next_state   = (num_samples == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (pair.in_valid && remaining == CNT_W'(1)) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // DRAIN is entered right after the last transfer, so stage 1 holds
        // the final sample and nothing can follow it. That sample is folded
        // into the accumulators on this same edge, which is why done rises
        // together with the last metric update.
        next_state = ST_DONE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign pair.in_ready = ready;
  assign xfer          = pair.in_valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            remaining <= '0;
    else if (accept_start) remaining <= num_samples;
    else if (xfer)         remaining <= remaining - CNT_W'(1);
  end

  // -------------------------------------------------------------------------
  // Stage 1: per-sample error terms
  // -------------------------------------------------------------------------
  always_comb begin
    diff  = {1'b0, pair.approx} - {1'b0, pair.exact};
    // A set sign bit means exact > approx; negate the low bits to get the
    // magnitude (the W-bit result is exact for every operand pair).
    abs_d = diff[W] ? (~diff[W-1:0] + W'(1)) : diff[W-1:0];
    hd_c  = HD_W'($countones(pair.approx ^ pair.exact));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_d     <= '0;
      s1_mism  <= 1'b0;
      s1_hd    <= '0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_d    <= abs_d;
        s1_mism <= (pair.approx != pair.exact);
        s1_hd   <= hd_c;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: accumulators (these are the metric outputs)
  // -------------------------------------------------------------------------
  always_comb begin
    sum_next = AW'(sum_abs_err) + AW'(s1_d);
    hd_next  = AW'(hd_total) + AW'(s1_hd);
    sum_sat  = (sum_next > AW'(SUM_MAX)) ? SUM_MAX : sum_next[SUM_W-1:0];
    hd_sat   = (hd_next > AW'(SUM_MAX)) ? SUM_MAX : hd_next[SUM_W-1:0];
  end

  // A start is only accepted in IDLE/DONE, where stage 1 is always empty, so
  // clearing and accumulating never compete for the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count   <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      hd_total    <= '0;
    end else if (accept_start) begin
      err_count   <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      hd_total    <= '0;
    end else if (s1_valid) begin
      // err_count is bounded by num_samples, so it cannot wrap.
      err_count   <= err_count + CNT_W'(s1_mism);
      sum_abs_err <= sum_sat;
      hd_total    <= hd_sat;
      if (s1_d > max_abs_err) max_abs_err <= s1_d;
    end
  end

endmodule : mult8_err_monitor

// File: tb/tb_mult8_err_monitor.sv
// ---------------------------------------------------------------------------
// tb_mult8_err_monitor
// Self-checking bench for mult8_err_monitor. Two instances: the default
// build (SUM_W=32) and a narrow build (SUM_W=8) for accumulator saturation.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mult8_err_monitor;

  localparam int W     = 16;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default build.
  logic             start_a;
  logic [CNT_W-1:0] num_a;
  logic             busy_a, done_a;
  logic [CNT_W-1:0] err_a;
  logic [31:0]      sum_a;
  logic [W-1:0]     max_a;
  logic [31:0]      hd_a;
  mult8_err_monitor_if #(.W(W)) bus_a ();

  // Narrow accumulator build.
  logic             start_b;
  logic [CNT_W-1:0] num_b;
  logic             busy_b, done_b;
  logic [CNT_W-1:0] err_b;
  logic [7:0]       sum_b;
  logic [W-1:0]     max_b;
  logic [7:0]       hd_b;
  mult8_err_monitor_if #(.W(W)) bus_b ();

  mult8_err_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .num_samples(num_a),
    .pair(bus_a), .busy(busy_a), .done(done_a), .err_count(err_a),
    .sum_abs_err(sum_a), .max_abs_err(max_a), .hd_total(hd_a)
  );

  mult8_err_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .num_samples(num_b),
    .pair(bus_b), .busy(busy_b), .done(done_b), .err_count(err_b),
    .sum_abs_err(sum_b), .max_abs_err(max_b), .hd_total(hd_b)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_a(input string tag, input logic [15:0] e_err, input logic [31:0] e_sum,
                         input logic [15:0] e_max, input logic [31:0] e_hd);
    check({tag, "_err_count"}, err_a, e_err);
    check({tag, "_sum_abs_err"}, sum_a, e_sum);
    check({tag, "_max_abs_err"}, max_a, e_max);
    check({tag, "_hd_total"}, hd_a, e_hd);
  endtask

  task automatic drive_a(input logic v, input logic [15:0] ap, input logic [15:0] ex);
    bus_a.in_valid = v;
    bus_a.approx   = ap;
    bus_a.exact    = ex;
  endtask

  // Stimulus pair plus cumulative metrics expected once it is accounted for.
  typedef struct {
    logic [15:0] approx;
    logic [15:0] exact;
    logic [15:0] err;
    logic [31:0] sum;
    logic [15:0] max_err;
    logic [31:0] hd;
  } vec_t;

  vec_t run1[4];
  vec_t run3[3];
  int   xfers;

  initial begin
    // 96^100 = 0x04 (1 bit), 300^256 = 0x2C (3 bits).
    run1[0] = '{16'd100, 16'd100, 16'd0, 32'd0,  16'd0,  32'd0};
    run1[1] = '{16'd96,  16'd100, 16'd1, 32'd4,  16'd4,  32'd1};
    run1[2] = '{16'd300, 16'd256, 16'd2, 32'd48, 16'd44, 32'd4};
    run1[3] = '{16'd0,   16'd0,   16'd2, 32'd48, 16'd44, 32'd4};
    // exact > approx, opposite-bit patterns, small difference.
    run3[0] = '{16'h0000, 16'hFFFF, 16'd1, 32'd65535, 16'd65535, 32'd16};
    run3[1] = '{16'hAAAA, 16'h5555, 16'd2, 32'd87380, 16'd65535, 32'd32};
    run3[2] = '{16'd7,    16'd3,    16'd3, 32'd87384, 16'd65535, 32'd33};

    start_a = 1'b0; num_a = '0; drive_a(1'b0, '0, '0);
    start_b = 1'b0; num_b = '0;
    bus_b.in_valid = 1'b0; bus_b.approx = '0; bus_b.exact = '0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_in_ready", bus_a.in_ready, 1'b0);
    check_a("rst", 0, 0, 0, 0);
    check("rst_b_done", done_b, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- run of 4 back-to-back pairs, live partial results ----
    start_a = 1'b1; num_a = 16'd4;
    @(negedge clk);
    start_a = 1'b0;
    check("t1_busy", busy_a, 1'b1);
    check("t1_in_ready", bus_a.in_ready, 1'b1);
    check_a("t1_start", 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      if (k >= 2) check_a($sformatf("t1_v%0d", k - 2), run1[k-2].err, run1[k-2].sum,
                          run1[k-2].max_err, run1[k-2].hd);
      if (k == 4) begin
        check("t1_drain_done", done_a, 1'b0);
        check("t1_drain_in_ready", bus_a.in_ready, 1'b0);
      end
      if (k == 5) begin
        check("t1_done", done_a, 1'b1);
        check("t1_done_busy", busy_a, 1'b0);
      end
      if (k < 4) drive_a(1'b1, run1[k].approx, run1[k].exact);
      else       drive_a(1'b0, '0, '0);
      @(negedge clk);
    end

    // ---- zero-sample run started from DONE: clears metrics, no transfers ----
    start_a = 1'b1; num_a = 16'd0;
    drive_a(1'b1, 16'd50, 16'd1);
    @(negedge clk);
    start_a = 1'b0;
    check("t2_done", done_a, 1'b1);
    check_a("t2", 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t2_in_ready_%0d", k), bus_a.in_ready, 1'b0);
      @(negedge clk);
    end
    check_a("t2_hold", 0, 0, 0, 0);
    drive_a(1'b0, '0, '0);

    // ---- num_samples=3, in_valid 1,0,1,0,1 then stuck high; start in RUN ----
    start_a = 1'b1; num_a = 16'd3;
    @(negedge clk);
    start_a = 1'b0;
    xfers = 0;
    for (int k = 0; k < 9; k++) begin
      start_a = 1'b0;
      case (k)
        0: drive_a(1'b1, run3[0].approx, run3[0].exact);
        1: begin drive_a(1'b0, '0, '0); start_a = 1'b1; num_a = 16'd1; end
        2: drive_a(1'b1, run3[1].approx, run3[1].exact);
        3: drive_a(1'b0, '0, '0);
        4: drive_a(1'b1, run3[2].approx, run3[2].exact);
        default: drive_a(1'b1, 16'd9999, 16'd0);
      endcase
      if (k == 4) begin
        check("t3_in_ready_last", bus_a.in_ready, 1'b1);
        check_a("t3_partial", run3[1].err, run3[1].sum, run3[1].max_err, run3[1].hd);
      end
      if (k == 5) check("t3_in_ready_after", bus_a.in_ready, 1'b0);
      if (k == 6) begin
        check("t3_done", done_a, 1'b1);
        check_a("t3_final", run3[2].err, run3[2].sum, run3[2].max_err, run3[2].hd);
      end
      #1;
      if (bus_a.in_valid && bus_a.in_ready) xfers++;
      @(negedge clk);
    end
    drive_a(1'b0, '0, '0);
    check("t3_transfers", xfers, 3);
    check_a("t3_hold", run3[2].err, run3[2].sum, run3[2].max_err, run3[2].hd);

    // ---- SUM_W=8 build: sum saturates at 255, hd_total fits ----
    start_b = 1'b1; num_b = 16'd2;
    @(negedge clk);
    start_b = 1'b0;
    bus_b.in_valid = 1'b1; bus_b.approx = 16'd0; bus_b.exact = 16'd255;
    @(negedge clk);
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    check("t4_partial_sum", sum_b, 8'd255);
    check("t4_partial_hd", hd_b, 8'd8);
    @(negedge clk);
    check("t4_done", done_b, 1'b1);
    check("t4_err_count", err_b, 16'd2);
    check("t4_sum_sat", sum_b, 8'd255);
    check("t4_max", max_b, 16'd255);
    check("t4_hd", hd_b, 8'd16);

    // ---- async reset after 2 of 5 samples, then a clean restart ----
    start_a = 1'b1; num_a = 16'd5;
    @(negedge clk);
    start_a = 1'b0;
    drive_a(1'b1, 16'd10, 16'd0);
    @(negedge clk);
    drive_a(1'b1, 16'd0, 16'd20);
    @(negedge clk);
    drive_a(1'b0, '0, '0);
    @(negedge clk);
    check("t5_busy_pre", busy_a, 1'b1);
    check_a("t5_partial", 2, 30, 20, 4);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy_a, 1'b0);
    check("t5_rst_done", done_a, 1'b0);
    check("t5_rst_in_ready", bus_a.in_ready, 1'b0);
    check_a("t5_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_idle_busy", busy_a, 1'b0);
    check("t5_idle_done", done_a, 1'b0);
    start_a = 1'b1; num_a = 16'd1;
    @(negedge clk);
    start_a = 1'b0;
    drive_a(1'b1, 16'd3, 16'd0);
    @(negedge clk);
    drive_a(1'b0, '0, '0);
    @(negedge clk);
    check("t5_restart_done", done_a, 1'b1);
    check_a("t5_restart", 1, 3, 3, 2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_mult8_err_monitor
